// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss-fill controller: FSM state
// encoding and block geometry.
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Words per cache block (8 x 16-bit words = 16 bytes).
  localparam int BLOCK_WORDS       = 8;
  // Byte-offset bits inside a block; these are cleared to form the base.
  localparam int BLOCK_OFFSET_BITS = 4;

endpackage : cache_fill_fsm_pkg

// File: rtl/cache_fill_fsm_fill_counter.sv
// Saturating up-counter used to track issued and received words of a
// block fill. Clears asynchronously on reset and synchronously on clr;
// holds once it reaches MAX.
module fill_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] COUNT_MAX = W'(MAX);

  // Count enabled events, stopping at COUNT_MAX; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create simulation races.
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != COUNT_MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule : fill_counter

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller in front of the 4-cycle pipelined main memory.
// On a miss it issues 8 back-to-back word reads for the 16-byte block,
// streams the returned words into the data array in order, writes the
// tag array on the last word and then drops fsm_busy.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [15:0]           memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array
);

  // Counters need one extra bit so they can hold the "all 8 done" value.
  localparam int                    CNT_W       = WORD_IDX_W + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL    = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);

  fill_state_t           state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      recv_cnt;

  logic filling;
  logic issuing;
  logic receiving;
  logic cnt_clr;

  assign filling   = (state == FILL);
  assign issuing   = filling && (issue_cnt < CNT_FULL);
  // Returns seen outside FILL are stale (e.g. after a mid-fill reset) and
  // are dropped here.
  assign receiving = filling && memory_data_valid && (recv_cnt < CNT_FULL);
  // Both counters sit at zero while idle, so a fill always starts from 0.
  assign cnt_clr   = !filling;

  fill_counter #(
    .W   (CNT_W),
    .MAX (BLOCK_WORDS)
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (issuing),
    .count (issue_cnt)
  );

  fill_counter #(
    .W   (CNT_W),
    .MAX (BLOCK_WORDS)
  ) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (receiving),
    .count (recv_cnt)
  );

  // Outputs are decoded straight from state/counters so the memory sees
  // a request in the very first FILL cycle.
  assign fsm_busy         = filling;
  assign mem_enable       = issuing;
  // base has a zero low nibble, so base + 2*issue_cnt never carries out
  // of the block.
  assign memory_address   = issuing ? (base + ADDR_WIDTH'({issue_cnt, 1'b0})) : '0;
  assign write_data_array = receiving;
  assign fill_word        = receiving ? recv_cnt[WORD_IDX_W-1:0] : '0;
  assign fill_data        = receiving ? memory_data : '0;
  assign write_tag_array  = receiving && (recv_cnt == CNT_LAST);

  // Control FSM: latch the block base on a miss, return to idle once the
  // last word has been written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state <= FILL;
            base  <= miss_address & ~OFFSET_MASK;
          end
        end
        FILL: begin
          if (write_tag_array) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A return after all 8 words were received means the memory or the
  // parent is out of step with this controller.
  a_no_excess_return : assert property (
    @(posedge clk) disable iff (!rst_n)
      !(filling && memory_data_valid && (recv_cnt == CNT_FULL))
  );
`endif

endmodule : cache_fill_fsm

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller that sits directly upstream of the 4-cycle pipelined main memory (memory4c).
- On a cache miss it issues back-to-back word reads for the whole 16-byte block.
- It collects the 8 returned words in order and streams them into the cache data array.
- It updates the tag array on the last word, then releases the pipeline stall.

Parameters:
ADDR_WIDTH, 16, byte-address width; matches memory address width.
WORD_IDX_W, 3, log2 of words per block (8 words x 2 bytes = 16-byte block).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
miss_detected  input  1  cache reports miss this cycle
miss_address  input  ADDR_WIDTH  byte address that missed
memory_data  input  16  read data from memory4c data_out
memory_data_valid  input  1  memory4c data_valid
fsm_busy  output  1  fill in progress; pipeline stalls while high
mem_enable  output  1  to memory4c enable (wr tied 0 by parent)
memory_address  output  ADDR_WIDTH  to memory4c addr, always even
write_data_array  output  1  write fill_data into data array this cycle
fill_word  output  WORD_IDX_W  word index within block for the data-array write
fill_data  output  16  word to write (equals memory_data)
write_tag_array  output  1  write tag/valid for the block this cycle

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time including mid-fill): state=IDLE; base, issue_cnt and recv_cnt cleared to 0.
- All outputs go to 0 immediately on reset.
- States: IDLE, FILL.
- IDLE:
  - Outputs fsm_busy=0, mem_enable=0, write_data_array=0, write_tag_array=0, memory_address=0.
  - memory_data_valid is ignored, which discards stale returns after a mid-fill reset.
  - If miss_detected=1 at posedge: latch base = miss_address with low 4 bits cleared; issue_cnt=0; recv_cnt=0; go FILL.
- FILL:
  - fsm_busy=1.
  - Issue: while issue_cnt<8, mem_enable=1 and memory_address = base + 2*issue_cnt; issue_cnt increments each cycle.
  - After 8 issues, mem_enable=0 and memory_address=0.
  - issue_cnt is 4 bits and saturates at 8.
  - Receive: when memory_data_valid=1, write_data_array=1, fill_word=recv_cnt, fill_data=memory_data; recv_cnt increments.
  - Receive is independent of and concurrent with issue.
  - Completion: when memory_data_valid=1 and recv_cnt=7, write_tag_array=1 in the same cycle; next state IDLE.
- Outputs are combinational from registered state and inputs; no extra output register.
- Timing, with F1 = first FILL cycle:
  - Requests occupy F1..F8.
  - Memory latency is 4 cycles, so valid data arrives F5..F12.
  - write_tag_array pulses at F12.
  - fsm_busy is high for exactly 12 cycles.
  - Next miss is accepted the cycle after F12.
- miss_detected while in FILL is ignored; base is not re-latched.
- Address wrap: base+14 never carries out of the block because base low nibble=0; no overflow handling needed.
- memory_data_valid while recv_cnt already 8 cannot occur legally; it is ignored and flagged by a simulation-only assertion.

Decomposition:
- Shared cache package holds:
  - state encoding localparams: IDLE=1'b0, FILL=1'b1
  - BLOCK_WORDS=8
  - BLOCK_OFFSET_BITS=4
- One natural sub-module, fill_counter: a WORD_IDX_W+1 bit saturating up-counter with async active-low clear, sync clear and enable.
- fill_counter is instantiated twice: issue counter and receive counter.

Test Plan:
- Reset then idle: rst_n=0 then 1, no miss for 10 cycles -> every output 0; memory_address=0.
- Single fill: miss_address=0x1236 -> mem_enable high 8 cycles with addresses 0x1230,0x1232,...,0x123E; write_data_array on F5..F12 with fill_word 0..7 and data matching memory image; write_tag_array only at F12; fsm_busy high exactly 12 cycles.
- Miss during fill: miss_detected=1 with 0x4000 at F3 -> ignored; all 8 addresses remain base 0x1230.
- Back-to-back misses: second miss (0xFFF0) asserted the cycle after F12 -> new fill starts immediately, addresses 0xFFF0..0xFFFE with no wrap into 0x0000.
- Reset mid-fill: rst_n=0 at F6 for 1 cycle -> outputs 0 asynchronously; state IDLE; trailing memory_data_valid pulses produce no write_data_array/write_tag_array.
- Fill at address 0: miss_address=0x0001 -> base 0x0000, addresses 0x0000..0x000E, fill_word sequence 0..7 in order.
